// File: rtl/ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage: ALU op encoding,
// architectural constants and the layout of the ID/EX pipeline register.
package ex_operand_stage_pkg;

  localparam int XLEN        = 32;
  localparam int REG_AW      = 5;
  localparam int SHAMT_WIDTH = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SRL    = 4'd3,
    ALU_SRA    = 4'd4,
    ALU_AND    = 4'd5,
    ALU_OR     = 4'd6,
    ALU_XOR    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_EQ     = 4'd10,
    ALU_SGE    = 4'd11,
    ALU_SGEU   = 4'd12,
    ALU_PASS_B = 4'd13
  } alu_op_t;

  // Registered ID/EX fields. The op is kept as raw bits so 14/15 pass through.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        aluselect;
    logic              a_sel;
    logic              b_sel;
    logic              reg_write;
    logic              mem_read;
  } id_ex_t;

  // Shift ops need operand B clipped to a legal shift amount.
  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding select for one source operand (the fwd_mux of this stage).
// EX/MEM beats MEM/WB; x0 is never forwarded; an EX/MEM load is not
// forwarded because load-use stalling keeps that case from being live.
// The MEM/WB path exists only when EX_OPERAND_WB_FWD_EN is defined; otherwise
// the register file is expected to bypass writeback data itself.
module ex_operand_stage_fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic                      exm_reg_write,
  input  logic                      exm_mem_read,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     data
);

  logic exm_hit;
  logic wb_hit;

  assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == rs) && !exm_mem_read;

`ifdef EX_OPERAND_WB_FWD_EN
  assign wb_hit = wb_reg_write && (wb_rd != '0) && (wb_rd == rs);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_reg_write, wb_result};
  assign wb_hit    = 1'b0;
`endif

  // Priority select: EX/MEM, then MEM/WB, then register file data.
  always_comb begin
    data = reg_data;
    if (exm_hit) begin
      data = exm_result;
    end else if (wb_hit) begin
`ifdef EX_OPERAND_WB_FWD_EN
      data = wb_result;
`endif
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and ALU operand selection.
// Optional MEM/WB forwarding: define EX_OPERAND_WB_FWD_EN.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,   // struct fields are sized from the package; keep equal
  parameter int REG_ADDR_WIDTH = REG_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [3:0]                id_aluselect,
  input  logic                      id_a_sel,
  input  logic                      id_b_sel,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] exm_rd,
  input  logic                      exm_reg_write,
  input  logic                      exm_mem_read,
  input  logic [DATA_WIDTH-1:0]     exm_result,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      wb_reg_write,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     input0,
  output logic [DATA_WIDTH-1:0]     input1,
  output logic [3:0]                aluselect,
  output logic                      ex_valid,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      load_use_stall
);

  localparam int NUM_SRC = 2;  // [0] = rs1, [1] = rs2

  id_ex_t id_in;
  id_ex_t ex_q;

  assign id_in = '{valid:     id_valid,
                   pc:        id_pc,
                   rs1_data:  id_rs1_data,
                   rs2_data:  id_rs2_data,
                   imm:       id_imm,
                   rs1:       id_rs1,
                   rs2:       id_rs2,
                   rd:        id_rd,
                   aluselect: id_aluselect,
                   a_sel:     id_a_sel,
                   b_sel:     id_b_sel,
                   reg_write: id_reg_write,
                   mem_read:  id_mem_read};

  // Pipeline register: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
    end else if (!stall) begin
      ex_q <= id_in;
    end
  end

  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0] src_rs;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     src_data;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     fwd_data;

  assign src_rs   = {ex_q.rs2, ex_q.rs1};
  assign src_data = {ex_q.rs2_data, ex_q.rs1_data};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    ex_operand_stage_fwd_mux #(
      .DATA_WIDTH    (DATA_WIDTH),
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd (
      .rs           (src_rs[s]),
      .reg_data     (src_data[s]),
      .exm_rd       (exm_rd),
      .exm_reg_write(exm_reg_write),
      .exm_mem_read (exm_mem_read),
      .exm_result   (exm_result),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .wb_result    (wb_result),
      .data         (fwd_data[s])
    );
  end

  logic [DATA_WIDTH-1:0] b_raw;

  // Operand selection; shift ops see only a 0..31 shift amount on input1.
  always_comb begin
    input0 = ex_q.a_sel ? ex_q.pc : fwd_data[0];
    b_raw  = ex_q.b_sel ? ex_q.imm : fwd_data[1];
    input1 = b_raw;
    if (is_shift(ex_q.aluselect)) begin
      input1 = {{(DATA_WIDTH-SHAMT_WIDTH){1'b0}}, b_raw[SHAMT_WIDTH-1:0]};
    end
  end

  assign aluselect     = ex_q.aluselect;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write & ex_q.valid;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_store_data = fwd_data[1];

  // A load in EX feeding the instruction in ID cannot be forwarded in time.
  assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != REG_ZERO) && id_valid &&
                          ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus reset/stall/flush sequences.
module tb_ex_operand_stage;

`ifdef EX_OPERAND_WB_FWD_EN
  localparam bit WB_FWD = 1'b1;
`else
  localparam bit WB_FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_aluselect;
  logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, exm_mem_read, wb_reg_write;
  logic [31:0] exm_result, wb_result;
  logic [31:0] input0, input1, ex_store_data;
  logic [3:0]  aluselect;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
  logic [4:0]  ex_rd;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_aluselect(id_aluselect),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
    .exm_mem_read(exm_mem_read), .exm_result(exm_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_result(wb_result), .input0(input0),
    .input1(input1), .aluselect(aluselect), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  typedef struct {
    string       name;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        a_sel, b_sel, rw, mr;
    logic [4:0]  exm_rd;
    logic        exm_rw, exm_mr;
    logic [31:0] exm_res;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [31:0] wb_res;
    logic [31:0] e_in0, e_in1, e_store;
    logic        e_lus;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
                          input logic [4:0] rs1, rs2, rd, input logic [3:0] op,
                          input logic a, b, rw, mr);
    id_valid = v; id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_aluselect = op;
    id_a_sel = a; id_b_sel = b; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic drive_fwd(input logic [4:0] erd, input logic erw, emr, input logic [31:0] eres,
                           input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    exm_rd = erd; exm_reg_write = erw; exm_mem_read = emr; exm_result = eres;
    wb_rd = wrd; wb_reg_write = wrw; wb_result = wres;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    // name pc rs1d rs2d imm rs1 rs2 rd op a b rw mr | exm rd rw mr res | wb rd rw res | in0 in1 store lus
    vecs[0]  = '{"exm_fwd_rs1", 32'h100, 32'hDEAD, 32'h11, 32'h0, 5'd5, 5'd6, 5'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd5, 1'b1, 1'b0, 32'h1234, 5'd0, 1'b0, 32'h0, 32'h1234, 32'h11, 32'h11, 1'b0};
    vecs[1]  = '{"exm_over_wb", 32'h104, 32'h10, 32'hCCCC, 32'h0, 5'd1, 5'd7, 5'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd7, 1'b1, 1'b0, 32'hAAAA, 5'd7, 1'b1, 32'hBBBB, 32'h10, 32'hAAAA, 32'hAAAA, 1'b0};
    vecs[2]  = '{"wb_only", 32'h108, 32'h10, 32'hCCCC, 32'h0, 5'd1, 5'd7, 5'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd9, 1'b1, 1'b0, 32'hAAAA, 5'd7, 1'b1, 32'hBBBB, 32'h10,
                 WB_FWD ? 32'hBBBB : 32'hCCCC, WB_FWD ? 32'hBBBB : 32'hCCCC, 1'b0};
    vecs[3]  = '{"x0_guard", 32'h10C, 32'h0, 32'h22, 32'h0, 5'd0, 5'd2, 5'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h5, 32'h0, 32'h22, 32'h22, 1'b0};
    vecs[4]  = '{"sll_mask", 32'h110, 32'h1, 32'h55, 32'h123, 5'd1, 5'd2, 5'd8, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h1, 32'h3, 32'h55, 1'b0};
    vecs[5]  = '{"add_nomask", 32'h114, 32'h1, 32'h55, 32'h123, 5'd1, 5'd2, 5'd8, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h1, 32'h123, 32'h55, 1'b0};
    vecs[6]  = '{"sra_reg_mask", 32'h118, 32'h1, 32'hFFFF_FF3F, 32'h0, 5'd1, 5'd2, 5'd8, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h1, 32'h1F, 32'hFFFF_FF3F, 1'b0};
    vecs[7]  = '{"pc_sel", 32'h2000, 32'h1, 32'h2, 32'h0, 5'd5, 5'd2, 5'd8, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0,
                 5'd5, 1'b1, 1'b0, 32'h7777, 5'd0, 1'b0, 32'h0, 32'h2000, 32'h2, 32'h2, 1'b0};
    vecs[8]  = '{"exm_load_nofwd", 32'h11C, 32'h4444, 32'h2, 32'h0, 5'd4, 5'd2, 5'd8, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd4, 1'b1, 1'b1, 32'h9999, 5'd0, 1'b0, 32'h0, 32'h4444, 32'h2, 32'h2, 1'b0};
    vecs[9]  = '{"op15_pass", 32'h120, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd8, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h3, 32'h4, 32'h4, 1'b0};
    vecs[10] = '{"load_self", 32'h124, 32'h3, 32'h4, 32'h8, 5'd1, 5'd3, 5'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1,
                 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h3, 32'h8, 32'h4, 1'b1};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    #12;
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_in0", input0, 32'h0);
    chk("rst_in1", input1, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Table: capture at one edge, check combinational outputs one cycle later.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_id(1'b1, vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm, vecs[i].rs1, vecs[i].rs2,
               vecs[i].rd, vecs[i].op, vecs[i].a_sel, vecs[i].b_sel, vecs[i].rw, vecs[i].mr);
      drive_fwd(vecs[i].exm_rd, vecs[i].exm_rw, vecs[i].exm_mr, vecs[i].exm_res,
                vecs[i].wb_rd, vecs[i].wb_rw, vecs[i].wb_res);
      tick();
      chk({vecs[i].name, "/in0"}, input0, vecs[i].e_in0);
      chk({vecs[i].name, "/in1"}, input1, vecs[i].e_in1);
      chk({vecs[i].name, "/store"}, ex_store_data, vecs[i].e_store);
      chk({vecs[i].name, "/op"}, 32'(aluselect), 32'(vecs[i].op));
      chk({vecs[i].name, "/rd"}, 32'(ex_rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "/valid"}, 32'(ex_valid), 32'h1);
      chk({vecs[i].name, "/lus"}, 32'(load_use_stall), 32'(vecs[i].e_lus));
    end

    // Load in EX, dependent instruction in ID: stall request, then flush+stall.
    @(negedge clk);
    drive_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    drive_id(1'b1, 32'h200, 32'h0, 32'h0, 32'h10, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 32'h204, 32'h5, 32'h6, 32'h0, 5'd1, 5'd3, 5'd9, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("lu_stall_req", 32'(load_use_stall), 32'h1);
    chk("lu_mem_read", 32'(ex_mem_read), 32'h1);
    id_valid = 1'b0;
    #1;
    chk("lu_id_invalid", 32'(load_use_stall), 32'h0);
    id_valid = 1'b1;
    stall = 1'b1; flush = 1'b1;
    tick();
    chk("flush_over_stall_valid", 32'(ex_valid), 32'h0);
    chk("flush_over_stall_rw", 32'(ex_reg_write), 32'h0);
    chk("flush_clears_lus", 32'(load_use_stall), 32'h0);
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("after_flush_rd", 32'(ex_rd), 32'd9);
    chk("after_flush_valid", 32'(ex_valid), 32'h1);

    // Stall alone holds fields.
    @(negedge clk);
    drive_id(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd10, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd11, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    tick();
    tick();
    chk("stall_rd", 32'(ex_rd), 32'd10);
    chk("stall_op", 32'(aluselect), 32'd5);
    chk("stall_in0", input0, 32'h300);
    chk("stall_rw", 32'(ex_reg_write), 32'h1);
    stall = 1'b0;
    tick();
    chk("unstall_rd", 32'(ex_rd), 32'd11);
    chk("unstall_in0", input0, 32'h304);

    // Bubble: invalid instruction never writes back.
    @(negedge clk);
    drive_id(1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd12, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bubble_valid", 32'(ex_valid), 32'h0);
    chk("bubble_rw", 32'(ex_reg_write), 32'h0);

    // Asynchronous reset between edges.
    @(negedge clk);
    drive_id(1'b1, 32'h500, 32'h77, 32'h88, 32'h0, 5'd1, 5'd2, 5'd13, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'h0);
    chk("async_rst_in0", input0, 32'h0);
    chk("async_rst_in1", input1, 32'h0);
    chk("async_rst_rd", 32'(ex_rd), 32'h0);
    tick();
    chk("rst_held_valid", 32'(ex_valid), 32'h0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post_rst_in0", input0, 32'h0);
    tick();
    chk("first_cap_valid", 32'(ex_valid), 32'h1);
    chk("first_cap_in0", input0, 32'h500);
    chk("first_cap_rd", 32'(ex_rd), 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
